serdes_tx_lanes: RTL and testbench

Parametrised multi-lane serial transmitter for the SERDES link. It accepts pre-encoded 10-bit line symbols per lane through a valid/ready interface and buffers them in a FIFO. It serialises them LSB-first at a run-time programmable bit rate, and inserts a comma symbol on every lane whenever no data is queued. This generalises the single-lane TX and fixed baud-select pair into one block with a lane count, FIFO depth and a full divider value. It sits between the encoder/data source and the GPIO pins.

---
 rtl/serdes_tx_lanes.sv | 126 ++++++++++++
 tb/tb_serdes_tx_lanes.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_tx_lanes.sv
// Multi-lane serial transmitter: FIFO-buffered line symbols serialised LSB-first
// at a programmable bit period, with COMMA fill on every lane whenever the FIFO is empty.
module serdes_tx_lanes #(
  parameter int               LANES = 1,
  parameter int               SYM_W = 10,
  parameter int               DEPTH = 8,
  parameter int               DIV_W = 16,
  parameter logic [SYM_W-1:0] COMMA = 10'b0101111100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DIV_W-1:0]             div_val,
  input  logic [LANES*SYM_W-1:0]       in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES-1:0]             ser_out,
  output logic                         bit_strobe,
  output logic                         sym_start,
  output logic                         comma_sent,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int W     = LANES * SYM_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] sh_q [LANES];
  logic [SYM_W-1:0] sh_d [LANES];
  logic [LANES-1:0] ser_q, ser_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             sym_start_q, sym_start_d;
  logic             comma_q, comma_d;
  logic             tick, boundary, push, pop;
  logic [W-1:0]     head;
  logic [SYM_W-1:0] load_sym;

  assign in_ready = in_ready_q & ~reset;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    push     = in_valid & in_ready;
    tick     = (cnt_q == div_q);
    boundary = tick & (idx_q == LAST_IDX);
    pop      = boundary & (level_q != '0);

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    // Divider only changes between symbols so a symbol never mixes bit periods.
    div_d = boundary ? div_val : div_q;

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    in_ready_d = (level_d != FULL_LVL);

    bit_strobe_d = tick;
    sym_start_d  = boundary;
    comma_d      = boundary & ~pop;

    ser_d    = ser_q;
    load_sym = '0;
    for (int k = 0; k < LANES; k++) begin
      sh_d[k]  = sh_q[k];
      load_sym = pop ? head[k*SYM_W +: SYM_W] : COMMA;
      if (boundary) begin
        ser_d[k] = load_sym[0];
        sh_d[k]  = load_sym >> 1;
      end else if (tick) begin
        ser_d[k] = sh_q[k][0];
        sh_d[k]  = sh_q[k] >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
      div_q        <= div_val;
      idx_q        <= LAST_IDX;
      ser_q        <= '0;
      bit_strobe_q <= 1'b0;
      sym_start_q  <= 1'b0;
      comma_q      <= 1'b0;
      for (int k = 0; k < LANES; k++) sh_q[k] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      ser_q        <= ser_d;
      bit_strobe_q <= bit_strobe_d;
      sym_start_q  <= sym_start_d;
      comma_q      <= comma_d;
      for (int k = 0; k < LANES; k++) sh_q[k] <= sh_d[k];
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign ser_out    = ser_q;
  assign bit_strobe = bit_strobe_q;
  assign sym_start  = sym_start_q;
  assign comma_sent = comma_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_serdes_tx_lanes.sv
// Bench for serdes_tx_lanes: a reset/idle vector table plus scoreboarded data
// symbols and hand-built sequences for divider change, push/pop overlap and reset.
module tb_serdes_tx_lanes;
  localparam int LANES = 2;
  localparam int SYM_W = 10;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
  localparam int W     = LANES * SYM_W;
  localparam logic [SYM_W-1:0] COMMA   = 10'b0101111100;
  localparam logic [W-1:0]     COMMA_W = {COMMA, COMMA};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] div_val = '0;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] ser_out;
  logic             bit_strobe, sym_start, comma_sent;
  logic [3:0]       fifo_level;

  serdes_tx_lanes #(.LANES(LANES), .SYM_W(SYM_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .COMMA(COMMA)) dut (
    .clk(clk), .reset(reset), .div_val(div_val), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .bit_strobe(bit_strobe), .sym_start(sym_start),
    .comma_sent(comma_sent), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] sb[$];
  bit           kind_q[$];
  bit           stall_seen = 1'b0;
  int           stall_lvl = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endfunction

  // Symbol monitor: rebuilds each symbol from bit strobes and checks it.
  logic [SYM_W-1:0] rx [LANES];
  int nbits = 0;
  bit synced = 1'b0;
  bit cur_comma = 1'b0;

  task automatic finish_sym();
    logic [W-1:0] got, exp;
    for (int k = 0; k < LANES; k++) got[k*SYM_W +: SYM_W] = rx[k];
    kind_q.push_back(cur_comma);
    if (cur_comma) chk("comma_sym", got, COMMA_W);
    else if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_data: got %0h expected no data symbol", got);
    end else begin
      exp = sb.pop_front();
      chk("data_sym", got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      nbits  = 0;
      synced = 1'b0;
    end else begin
      if (sym_start) chk("ss_has_strobe", bit_strobe, 1);
      if (comma_sent) chk("cs_has_ss", sym_start, 1);
      if (bit_strobe) begin
        if (sym_start) begin
          if (synced) chk("sym_len", nbits, SYM_W);
          synced    = 1'b1;
          nbits     = 0;
          cur_comma = comma_sent;
        end
        if (synced) begin
          if (nbits < SYM_W)
            for (int k = 0; k < LANES; k++) rx[k][nbits] = ser_out[k];
          nbits++;
          if (nbits == SYM_W) finish_sym();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sym(input string name, input int limit, output int at);
    int n = 0;
    @(negedge clk);
    while (!sym_start && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, sym_start, 1);
    at = cyc;
  endtask

  task automatic push_word(input logic [W-1:0] w, output int acc);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      if (!stall_seen) begin
        stall_seen = 1'b1;
        stall_lvl  = fifo_level;
      end
      @(negedge clk);
      n++;
    end
    chk("push_accept", in_ready, 1);
    if (in_ready) sb.push_back(w);
    acc = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_sb(input string name, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  typedef struct {
    logic ser;
    logic strobe;
    logic ss;
    logic cs;
    logic rdy;
  } vec_t;
  vec_t tv [12];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, d, e, s, s2, dummy, first, last, nd, gap, n, off, ss_off;
    int exp_off [13];
    int got_off [13];
    logic [W-1:0] w5;

    // Cycle 0 is the first cycle with reset low; comma bits 0,0,1,1,1,1,1,0,1,0.
    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_off = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 25, 30, 35};

    // Test 1: reset values and continuous comma idle at div 0.
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ser", ser_out, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_strobe", {bit_strobe, sym_start, comma_sent}, 0);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t1_ser", ser_out, {2{tv[c].ser}});
      chk("t1_strobe", bit_strobe, tv[c].strobe);
      chk("t1_sym_start", sym_start, tv[c].ss);
      chk("t1_comma_sent", comma_sent, tv[c].cs);
      chk("t1_ready", in_ready, tv[c].rdy);
      chk("t1_level", fifo_level, 0);
      step();
    end

    // Test 2: one word at div 3, latency bound and comma resumption.
    div_val = 16'd3;
    wait_sym("t2_sync", 20, dummy);
    step();
    push_word({10'h2AA, 10'h155}, a);
    n = 0;
    @(negedge clk);
    while (!(sym_start && !comma_sent) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t2_data_start", sym_start & ~comma_sent, 1);
    d = cyc;
    chk("t2_latency_ok", (d - a >= 2) && (d - a <= 41), 1);
    chk("t2_first_bits", ser_out, 2'b01);
    step();
    wait_sym("t2_next_sym", 60, e);
    chk("t2_sym_period", e - d, 40);
    chk("t2_comma_resumes", comma_sent, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Test 3: ten-word burst at div 1 fills the FIFO and streams without gaps.
    div_val = 16'd1;
    step();
    wait_sym("t3_sync", 50, dummy);
    kind_q.delete();
    stall_seen = 1'b0;
    step();
    for (int i = 1; i <= 10; i++) push_word({10'(i) ^ 10'h3F0, 10'(i)}, dummy);
    wait_sb("t3_all_sent", 400);
    first = -1; last = -1; nd = 0; gap = 0;
    for (int i = 0; i < kind_q.size(); i++)
      if (!kind_q[i]) begin
        if (first < 0) first = i;
        last = i;
        nd++;
      end
    if (first >= 0)
      for (int i = first; i <= last; i++) if (kind_q[i]) gap++;
    chk("t3_data_count", nd, 10);
    chk("t3_gap_commas", gap, 0);
    chk("t3_stall_seen", stall_seen, 1);
    chk("t3_stall_level", stall_lvl, 8);

    // Test 4: push coincides with pop at level 3.
    step();
    wait_sym("t4_sync", 40, s);
    step();
    for (int i = 0; i < 4; i++) push_word({10'h100 + 10'(i), 10'h200 + 10'(i)}, dummy);
    wait_sym("t4_pop1", 40, s2);
    chk("t4_level_before", fifo_level, 3);
    chk("t4_first_is_data", comma_sent, 0);
    repeat (19) step();
    w5 = {10'h155, 10'h0F0};
    in_data  = w5;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t4_level_at_push", fifo_level, 3);
    chk("t4_ready_at_push", in_ready, 1);
    if (in_ready) sb.push_back(w5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_level_after", fifo_level, 3);
    chk("t4_pop_same_cycle", sym_start & ~comma_sent, 1);
    wait_sb("t4_all_sent", 200);

    // Test 5: div change at bit 5 applies from the next symbol only.
    step();
    wait_sym("t5_sync", 40, s);
    for (int i = 0; i < 13; i++) got_off[i] = 0;
    n = 0; off = 0; ss_off = 0;
    while (n < 13 && off < 100) begin
      step();
      off++;
      if (off == 10) div_val = 16'd4;
      @(negedge clk);
      if (bit_strobe) begin
        got_off[n] = off;
        n++;
      end
      if (sym_start && ss_off == 0) ss_off = off;
    end
    for (int i = 0; i < 13; i++) chk("t5_strobe_offset", got_off[i], exp_off[i]);
    chk("t5_sym_offset", ss_off, 20);

    // Test 6: reset at bit 6 with four words queued discards them.
    div_val = 16'd1;
    step();
    wait_sym("t6_sync", 60, s);
    step();
    for (int i = 0; i < 4; i++) push_word({10'h3C0 + 10'(i), 10'h03C + 10'(i)}, dummy);
    n = 0;
    while (cyc < s + 12 && n < 50) begin
      step();
      n++;
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t6_level_queued", fifo_level, 4);
    chk("t6_bit6_strobe", bit_strobe, 1);
    chk("t6_ready_in_reset", in_ready, 0);
    step();
    @(negedge clk);
    chk("t6_ser_cleared", ser_out, 0);
    chk("t6_level_cleared", fifo_level, 0);
    chk("t6_flags_cleared", {bit_strobe, sym_start, comma_sent}, 0);
    step();
    reset = 1'b0;
    kind_q.delete();
    repeat (75) step();
    nd = 0;
    for (int i = 0; i < kind_q.size(); i++) if (!kind_q[i]) nd++;
    chk("t6_symbols_seen", kind_q.size() >= 3, 1);
    chk("t6_only_commas", nd, 0);
    chk("t6_ready_after", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
